// File: rtl/synapse_scan_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// synapse_scan_ctrl_pkg
// Shared definitions for the Synapse scan scheduler:
//   - scanState_t : scheduler state encoding (IDLE=0, ISSUE=1, DRAIN=2)
//   - modeWidth() : mode field width as a function of the token type
//   - sofBit()/eofBit()/modeLsb() and ADDR_LSB : token field positions in
//     {sof, eof, mode[CW-1:0], addr[AW-1:0]}, MSB first
// ----------------------------------------------------------------------------
package synapse_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } scanState_t;

   // "rc" tokens carry two mode bits, every other token type carries one.
   function automatic int modeWidth(input bit isRc);
      return isRc ? 2 : 1;
   endfunction

   function automatic int sofBit(input int cw, input int aw);
      return cw + aw + 1;
   endfunction

   function automatic int eofBit(input int cw, input int aw);
      return cw + aw;
   endfunction

   function automatic int modeLsb(input int aw);
      return aw;
   endfunction

   localparam int ADDR_LSB = 0;

endpackage

// File: rtl/synapse_credit_counter.sv
// ----------------------------------------------------------------------------
// synapse_credit_counter
// Tracks tokens issued to the Synapse but not yet completed.
//   iCLK, iRST   : clock, asynchronous active-high reset
//   iInc         : a token was issued this cycle
//   iDec         : a token completed this cycle
//   oCount       : tokens currently in flight, 0..MAX_INFLIGHT
//   oFull        : oCount has reached MAX_INFLIGHT
//   oUnderflow   : a completion arrived while nothing was in flight
// ----------------------------------------------------------------------------
module synapse_credit_counter #(
   parameter  int MAX_INFLIGHT = 4,
   localparam int CNTW         = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic            iCLK,
   input  logic            iRST,
   input  logic            iInc,
   input  logic            iDec,
   output logic [CNTW-1:0] oCount,
   output logic            oFull,
   output logic            oUnderflow
);

   logic decValid;

   // A completion with nothing outstanding is reported, never counted, so
   // the counter cannot wrap below zero.
   assign decValid   = iDec && (oCount != '0);
   assign oUnderflow = iDec && (oCount == '0);
   assign oFull      = (oCount == CNTW'(MAX_INFLIGHT));

   // NOTE: asynchronous reset belongs in the sensitivity list; state updates
   // use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         oCount <= '0;
      end else if (iInc && !decValid && !oFull) begin
         oCount <= oCount + CNTW'(1);
      end else if (!iInc && decValid) begin
         oCount <= oCount - CNTW'(1);
      end
   end

endmodule

// File: rtl/synapse_scan_ctrl.sv
// ----------------------------------------------------------------------------
// synapse_scan_ctrl
// Scheduler in front of one Synapse: scans a window of presynaptic rows by
// issuing {sof, eof, mode, addr} tokens on the AS channel, counts tokens in
// flight by monitoring the BM handshake, and owns the shared weight-write
// port so weights only change when no scan is active or draining.
//   iCLK, iRST                         : clock, asynchronous active-high reset
//   iValid_Start/oReady_Start          : scan request handshake
//   iBase, iCount, iMode               : scan window and mode, sampled at start
//   oBusy, oDone, oErr                 : status (busy, done pulse, sticky error)
//   oValid_AS/iReady_AS/oData_AS       : token channel to the Synapse
//   iValid_BM, iReady_BM               : monitored completion handshake
//   iWE_Host/iAddr_Host/iData_Host     : host weight write request
//   oReady_Host                        : host write granted this cycle
//   oWE_Weit/oAddr_Weit/oData_Weit     : weight write port to the Synapse
// ----------------------------------------------------------------------------
module synapse_scan_ctrl
   import synapse_scan_ctrl_pkg::*;
#(
   parameter  int NA           = 4,
   parameter  int NB           = 4,
   parameter  int WD           = 4,
   parameter      TYPE         = "rc",
   parameter  int MAX_INFLIGHT = 4,
   localparam int AW           = $clog2(NA),
   localparam int WAW          = $clog2(NA * NB),
   localparam int CW           = modeWidth(TYPE == "rc"),
   localparam int TW           = 2 + CW + AW
) (
   input  logic           iCLK,
   input  logic           iRST,
   input  logic           iValid_Start,
   output logic           oReady_Start,
   input  logic [AW-1:0]  iBase,
   input  logic [AW:0]    iCount,
   input  logic [CW-1:0]  iMode,
   output logic           oBusy,
   output logic           oDone,
   output logic           oErr,
   output logic           oValid_AS,
   input  logic           iReady_AS,
   output logic [TW-1:0]  oData_AS,
   input  logic           iValid_BM,
   input  logic           iReady_BM,
   input  logic           iWE_Host,
   input  logic [WAW-1:0] iAddr_Host,
   input  logic [WD-1:0]  iData_Host,
   output logic           oReady_Host,
   output logic           oWE_Weit,
   output logic [WAW-1:0] oAddr_Weit,
   output logic [WD-1:0]  oData_Weit
);

   localparam int CNTW = $clog2(MAX_INFLIGHT + 1);
   localparam int SOF  = sofBit(CW, AW);
   localparam int EOF  = eofBit(CW, AW);
   localparam int MLSB = modeLsb(AW);

   scanState_t      state, nextState;
   logic [AW-1:0]   addr;
   logic [AW-1:0]   nextAddr;
   logic [AW:0]     remaining;
   logic [CW-1:0]   mode;
   logic            sofFlag;
   logic [CNTW-1:0] inflight;
   logic            creditFull;
   logic            underflow;
   logic            startHs;
   logic            asHs;
   logic            bmHs;
   logic            drainEmpty;

   assign startHs = iValid_Start & oReady_Start;
   assign asHs    = oValid_AS & iReady_AS;
   assign bmHs    = iValid_BM & iReady_BM;

   // Drain ends when nothing is outstanding, or the last completion lands now.
   assign drainEmpty = (inflight == '0) || ((inflight == CNTW'(1)) && bmHs);

   assign nextAddr = (addr == AW'(NA - 1)) ? '0 : addr + AW'(1);

   synapse_credit_counter #(
      .MAX_INFLIGHT (MAX_INFLIGHT)
   ) uCredit (
      .iCLK       (iCLK),
      .iRST       (iRST),
      .iInc       (asHs),
      .iDec       (bmHs),
      .oCount     (inflight),
      .oFull      (creditFull),
      .oUnderflow (underflow)
   );

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) state <= IDLE;
      else      state <= nextState;
   end

   // NOTE: every output of this block gets a default before the case so no
   // path leaves a variable unassigned, which would infer a latch.
   always_comb begin
      nextState    = state;
      oReady_Start = 1'b0;
      oReady_Host  = 1'b0;
      oValid_AS    = 1'b0;
      case (state)
         IDLE: begin
            oReady_Host  = 1'b1;
            // A host write in the same cycle wins; the start retries next cycle.
            oReady_Start = !iWE_Host;
            if (iValid_Start && !iWE_Host && (iCount != '0)) nextState = ISSUE;
         end
         ISSUE: begin
            // Credit only drops while waiting, so a raised valid stays up.
            oValid_AS = !creditFull;
            if (!creditFull && iReady_AS && (remaining == (AW+1)'(1))) nextState = DRAIN;
         end
         DRAIN: begin
            if (drainEmpty) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         addr      <= '0;
         remaining <= '0;
         mode      <= '0;
         sofFlag   <= 1'b0;
         oDone     <= 1'b0;
         oErr      <= 1'b0;
      end else begin
         oDone <= (startHs && (iCount == '0)) || ((state == DRAIN) && drainEmpty);
         if (underflow) oErr <= 1'b1;
         if (startHs && (iCount != '0)) begin
            addr      <= iBase;
            remaining <= iCount;
            mode      <= iMode;
            sofFlag   <= 1'b1;
         end else if (asHs) begin
            addr      <= nextAddr;
            remaining <= remaining - (AW+1)'(1);
            sofFlag   <= 1'b0;
         end
      end
   end

   // Token is assembled purely from registered fields, so it is stable while
   // the Synapse backpressures and reads zero out of reset.
   always_comb begin
      oData_AS                 = '0;
      oData_AS[SOF]            = sofFlag;
      oData_AS[EOF]            = (remaining == (AW+1)'(1));
      oData_AS[MLSB +: CW]     = mode;
      oData_AS[ADDR_LSB +: AW] = addr;
   end

   assign oBusy      = (state != IDLE);
   assign oWE_Weit   = iWE_Host & oReady_Host;
   assign oAddr_Weit = iAddr_Host;
   assign oData_Weit = iData_Host;

endmodule
